// File: rtl/trng_collector.sv
// trng_collector: gates the ring-oscillator TRNG, discards warm-up bits, runs a repetition-count
// health test and packs bits into words behind a FWFT FIFO. Optional macro: TRNG_VN_DEBIAS_EN.
module trng_collector #(
  parameter int WIDTH         = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int WARMUP_CYCLES = 64,
  parameter int RUN_LIMIT     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable_i,
  input  logic                            clear_alarm_i,
  output logic                            trng_en_o,
  input  logic                            trng_bit_i,
  output logic [WIDTH-1:0]                data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
  output logic                            alarm_o
);

  localparam int WW = $clog2(WARMUP_CYCLES);
  localparam int RW = $clog2(RUN_LIMIT + 1);
  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(RUN_LIMIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [LW-1:0] FIFO_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, ALARM} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    warmCnt_q, warmCnt_d;
  logic [RW-1:0]    runCnt_q, runCnt_d;
  logic             prevBit_q, prevBit_d;
  logic [BW-1:0]    bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pushWord;
  logic             accept, acceptBit, push, flush;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q;
  logic             pop, pushOk;

`ifdef TRNG_VN_DEBIAS_EN
  logic pairPhase_q, pairPhase_d, pairBit_q, pairBit_d;
`endif

  assign trng_en_o = (state_q == WARMUP) || (state_q == COLLECT);
  assign alarm_o   = (state_q == ALARM);
  assign valid_o   = (count_q != '0);
  assign level_o   = count_q;
  assign data_o    = valid_o ? mem_q[rdPtr_q] : hold_q;

  // Bit acceptance; the debiaser pairs raw bits and keeps the first bit of an unequal pair.
  always_comb begin
    accept    = 1'b0;
    acceptBit = trng_bit_i;
`ifdef TRNG_VN_DEBIAS_EN
    pairPhase_d = 1'b0;
    pairBit_d   = pairBit_q;
    if (state_q == COLLECT) begin
      pairPhase_d = ~pairPhase_q;
      if (!pairPhase_q) begin
        pairBit_d = trng_bit_i;
      end else begin
        accept    = (pairBit_q != trng_bit_i);
        acceptBit = pairBit_q;
      end
    end
`else
    accept = (state_q == COLLECT);
`endif
  end

  always_comb begin
    state_d   = state_q;
    warmCnt_d = '0;
    runCnt_d  = '0;
    prevBit_d = prevBit_q;
    bitCnt_d  = '0;
    shift_d   = '0;
    push      = 1'b0;
    flush     = 1'b0;
    pushWord  = {shift_q[WIDTH-2:0], acceptBit};
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = WARMUP;
      end
      WARMUP: begin
        if (!enable_i)                  state_d = IDLE;
        else if (warmCnt_q == WARM_LAST) state_d = COLLECT;
        else                            warmCnt_d = warmCnt_q + WW'(1);
      end
      COLLECT: begin
        prevBit_d = trng_bit_i;
        if ((runCnt_q == '0) || (trng_bit_i != prevBit_q)) runCnt_d = RW'(1);
        else if (runCnt_q == RUN_MAX)                      runCnt_d = runCnt_q;
        else                                               runCnt_d = runCnt_q + RW'(1);
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        if (accept) begin
          shift_d = pushWord;
          if (bitCnt_q == BIT_LAST) begin
            push     = 1'b1;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + BW'(1);
          end
        end
        // A health failure wins over everything, including a word completing this cycle.
        if (runCnt_d == RUN_MAX) begin
          state_d  = ALARM;
          flush    = 1'b1;
          push     = 1'b0;
          shift_d  = '0;
          bitCnt_d = '0;
        end else if (!enable_i) begin
          state_d = IDLE;
        end
      end
      ALARM: begin
        if (clear_alarm_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      warmCnt_q <= '0;
      runCnt_q  <= '0;
      prevBit_q <= 1'b0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
`ifdef TRNG_VN_DEBIAS_EN
      pairPhase_q <= 1'b0;
      pairBit_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      warmCnt_q <= warmCnt_d;
      runCnt_q  <= runCnt_d;
      prevBit_q <= prevBit_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
`ifdef TRNG_VN_DEBIAS_EN
      pairPhase_q <= pairPhase_d;
      pairBit_q   <= pairBit_d;
`endif
    end
  end

  // A full FIFO still accepts a push when the head is being popped in the same cycle.
  always_comb begin
    pop     = valid_o && ready_i && !flush;
    pushOk  = push && ((count_q != FIFO_FULL) || pop);
    count_d = count_q + LW'(pushOk) - LW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      hold_q <= data_o;
      if (flush) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        count_q <= '0;
      end else begin
        if (pushOk) wrPtr_q <= wrPtr_q + PW'(1);
        if (pop)    rdPtr_q <= rdPtr_q + PW'(1);
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= pushWord;
  end

endmodule
